// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage for the synchronous FIFO: issues reads, absorbs the one-cycle read
// latency in a 2-entry skid buffer and streams words out. Optional framing: STREAMER_LAST_EN.
module fifo_rd_streamer #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  idle,
    output logic                  err_underflow
);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("fifo_rd_streamer: BURST_LEN must be in 1..256");
    end

    // Buffer state
    logic [FIFO_WIDTH-1:0] slot_q [2];
    logic [FIFO_WIDTH-1:0] slot_d [2];
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  head_q, head_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic [2:0]            level;
    logic                  wr_idx;

    always_comb begin
        pop        = m_valid && m_ready;
        // occ + inflight - pop never underflows: pop implies occ >= 1
        level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rst && enable && !fifo_empty && (level < 3'd2);

        // A capture only happens with occ <= 1, so head + occ (mod 2) is head ^ occ[0]
        wr_idx     = head_q ^ occ_q[0];

        slot_d[0]  = slot_q[0];
        slot_d[1]  = slot_q[1];
        if (inflight_q) begin
            slot_d[wr_idx] = fifo_data_out;
        end

        occ_d      = level[1:0];
        head_d     = head_q ^ pop;
        inflight_d = fifo_rd_en;
        err_d      = err_q | fifo_underflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            slot_q[0]  <= slot_d[0];
            slot_q[1]  <= slot_d[1];
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            err_q      <= err_d;
        end
    end

    // Outputs come straight from registers; m_ready never reaches m_data
    always_comb begin
        m_valid       = (occ_q != 2'd0);
        m_data        = slot_q[head_q];
        idle          = (occ_q == 2'd0) && !inflight_q;
        err_underflow = err_q;
    end

`ifdef STREAMER_LAST_EN
    localparam logic [7:0] BeatMax = 8'(BURST_LEN - 1);

    logic [7:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == BeatMax) ? 8'd0 : beat_q + 8'd1;
        end
        m_last = m_valid && (beat_q == BeatMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= 8'd0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    always_comb begin
        m_last = 1'b0;
    end
`endif

endmodule

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

Read-side drain stage placed directly downstream of the synchronous FIFO. It issues `fifo_rd_en` against the FIFO's `empty` flag, absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer, and presents the words on a valid/ready stream at full throughput. It also supports optional burst framing (`m_last`) and sticky underflow error capture.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, data word width; must match the FIFO.
- `BURST_LEN`, 4, beats per frame for `m_last`; legal range 1..256.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new FIFO reads; deassertion drains the block without discarding data.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted read.
- `fifo_empty`  in  1  FIFO empty flag (combinational from FIFO count).
- `fifo_underflow`  in  1  FIFO underflow flag.
- `fifo_rd_en`  out  1  read request to the FIFO (combinational).
- `m_data`  out  FIFO_WIDTH  stream data (head of the buffer).
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  final beat of a frame (framing build only).
- `idle`  out  1  high when the buffer is empty and no read is in flight.
- `err_underflow`  out  1  sticky; set by `fifo_underflow`.

## Operation
- State:
  - `occ` (0..2): buffer occupancy.
  - `inflight` (1 bit): `fifo_rd_en` registered.
  - `head` (1 bit): ring read pointer.
  - `beat` (8 bit): frame beat counter.
  - `err` (1 bit): sticky underflow flag.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop) < 2`. Evaluate the sum with 3-bit unsigned width; it never goes negative because `pop` implies `occ ≥ 1`.
- Capture: when `inflight` is 1, `fifo_data_out` is written into slot `head + occ` (mod 2) at the edge.
- Occupancy update: `occ <= occ + inflight - pop`.
- Pop: `head` toggles on `pop`.
- Stream outputs: `m_valid = (occ != 0)`; `m_data = slot[head]`.
  - While `m_valid && !m_ready`, `m_data` and `m_last` are held stable.
- Framing:
  - `beat` increments on each `pop` and wraps from `BURST_LEN-1` to 0.
  - `m_last = m_valid && (beat == BURST_LEN-1)`.
  - With `BURST_LEN` = 1, every beat is last.
- `idle = (occ == 0) && !inflight`.
- Enable low: no new reads are issued; the in-flight word and buffered words are still delivered, and `idle` rises when done.
- Ordering: words leave in the exact FIFO read order; no duplication or drop.
- Underflow: `err` is set when `fifo_underflow` is 1 at an edge and is cleared only by `rst`. The datapath is unaffected.

## Timing
- Reset values:
  - `m_valid`, `m_last`, `err_underflow`, `fifo_rd_en` are 0.
  - `idle` is 1.
  - `m_data` is 0; buffer slots, `occ`, `inflight`, `head`, `beat` are all cleared.
- Latency: `fifo_rd_en` high at edge N → word captured at edge N+1 → `m_valid` high after N+1. First word appears 2 edges after the request.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, the block sustains one beat per cycle (steady state `occ`=1, `inflight`=1).
- Backpressure: with `m_ready` low, at most 2 words are held; `fifo_rd_en` drops once `occ + inflight` = 2.
- Simultaneous capture and pop: both are applied at the same edge and `occ` is unchanged.
- FIFO empty: `fifo_rd_en` is 0 and the block never causes an underflow itself.
- Reset mid-transfer: buffered and in-flight words are discarded, `beat` restarts at 0, and `err` clears.
- The FIFO read is registered; no combinational path exists from `m_ready` to `m_data`.

## Configuration
- `STREAMER_LAST_EN`:
  - Defined: the `beat` counter and `m_last` logic are built as specified.
  - Undefined: `beat` is removed, `m_last` is tied to 0, and `BURST_LEN` is ignored.

## Test plan
- Reset: assert `rst` mid-stream with 2 words buffered → all outputs at reset values within the same cycle; after release, the first FIFO word out is the next unread word.
- Streaming: FIFO preloaded with 8 words 0x0001..0x0008, `m_ready`=1, `enable`=1 → 8 consecutive beats starting 2 cycles after the first `fifo_rd_en`, in order, with `m_last` on beats 4 and 8.
- Backpressure: hold `m_ready`=0 for 5 cycles during streaming → `occ` stays at 2, `fifo_rd_en`=0, `m_data` stable; resume with no loss or duplicate.
- Empty FIFO: `fifo_empty`=1 with `enable`=1 for 10 cycles → `fifo_rd_en` never asserts, `m_valid`=0, `idle`=1, `err_underflow`=0.
- Enable drop: deassert `enable` with 1 word in flight and 1 buffered → exactly 2 more beats, then `idle`=1.
- Underflow flag: pulse `fifo_underflow` for 1 cycle → `err_underflow`=1 and it stays high until `rst`.
